v810_icache: RTL

Direct-mapped instruction cache between the execution unit's fetch port (IA/ID/IREQ/IACK) and the memory access unit's instruction port (EUIA/EUID/EUIREQ/EUIACK). On a hit it returns the fetch word without a bus cycle. On a miss it fills an 8-byte line with two MAU requests, then responds. This replaces the "I$ always hit" direct-ROM bypass in the device bench with real cache behaviour.

---
 rtl/v810_icache.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/v810_icache.sv
// Direct-mapped 1 KB instruction cache (8-byte lines) between EU fetch port and MAU fetch port.
// Latency: hit acks 1 cycle after IREQ; miss acks 4 cycles after IREQ plus MAU wait states; bypass acks with MIACK.
// Backpressure: EU holds IREQ/IA until IACK; cache holds MIREQ/MIA until MIACK; CE=0 freezes everything.
module v810_icache #(
  parameter int LINES_LOG2 = 7
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] IA,
  input  logic        IREQ,
  output logic [31:0] ID,
  output logic        IACK,
  output logic [31:0] MIA,
  output logic        MIREQ,
  input  logic [31:0] MID,
  input  logic        MIACK,
  input  logic        ICEN,
  input  logic        ICCLR,
  output logic        BUSY
);

  localparam int LINES = 1 << LINES_LOG2;
  localparam int TAG_W = 32 - LINES_LOG2 - 3;

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_LOOKUP, S_FILL0, S_FILL1, S_RESP, S_BYPASS
  } state_t;

  state_t state, state_nxt;

  logic [LINES_LOG2-1:0] clr_idx;
  logic                  clr_pend;
  logic [LINES_LOG2-1:0] rd_idx;
  logic                  rd_off;
  logic [31:0]           cap0, cap1;

  logic [31:0]      data_mem  [2*LINES];
  logic [TAG_W-1:0] tag_mem   [LINES];
  logic             valid_mem [LINES];

  logic [LINES_LOG2-1:0] ia_idx;
  logic [TAG_W-1:0]      ia_tag;
  logic [31:0]           rd_word;
  logic                  hit;
  logic                  unused_ia;

  assign ia_idx    = IA[LINES_LOG2+2:3];
  assign ia_tag    = IA[31:LINES_LOG2+3];
  assign unused_ia = ^IA[1:0];

  // RAM read port: address registered in IDLE, array read from the registered address
  assign rd_word = data_mem[{rd_idx, rd_off}];
  assign hit     = valid_mem[rd_idx] && (tag_mem[rd_idx] == ia_tag);

  // State register: reset forces a fresh invalidate sweep
  always_ff @(posedge CLK) begin
    if (RES)
      state <= S_CLEAR;
    else if (CE)
      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:  if (&clr_idx) state_nxt = S_IDLE;
      S_IDLE: begin
        if (clr_pend)
          state_nxt = S_CLEAR;
        else if (IREQ)
          state_nxt = ICEN ? S_LOOKUP : S_BYPASS;
      end
      S_LOOKUP: state_nxt = hit ? S_IDLE : S_FILL0;
      S_FILL0:  if (MIACK) state_nxt = S_FILL1;
      S_FILL1:  if (MIACK) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      S_BYPASS: if (MIACK) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the current state; bypass passes the MAU handshake straight through
  always_comb begin
    IACK  = 1'b0;
    MIREQ = 1'b0;
    MIA   = 32'd0;
    ID    = 32'd0;
    BUSY  = RES || (state == S_CLEAR);
    case (state)
      S_LOOKUP: begin
        IACK = hit;
        ID   = hit ? rd_word : 32'd0;
      end
      S_FILL0: begin
        MIREQ = 1'b1;
        MIA   = {IA[31:3], 3'b000};
      end
      S_FILL1: begin
        MIREQ = 1'b1;
        MIA   = {IA[31:3], 3'b100};
      end
      S_RESP: begin
        IACK = 1'b1;
        ID   = IA[2] ? cap1 : cap0;
      end
      S_BYPASS: begin
        MIREQ = IREQ;
        MIA   = {IA[31:2], 2'b00};
        ID    = MID;
        IACK  = MIACK && CE;
      end
      default: ;
    endcase
  end

  // Control registers: sweep counter, pending-clear flag, read address and fill capture
  always_ff @(posedge CLK) begin
    if (RES) begin
      clr_idx  <= '0;
      clr_pend <= 1'b0;
      rd_idx   <= '0;
      rd_off   <= 1'b0;
      cap0     <= 32'd0;
      cap1     <= 32'd0;
    end else if (CE) begin
      // flag is consumed when IDLE hands over to CLEAR; a new pulse always re-arms it
      clr_pend <= ICCLR || (clr_pend && (state != S_IDLE));
      if (state == S_CLEAR)
        clr_idx <= clr_idx + LINES_LOG2'(1);
      if (state == S_IDLE) begin
        rd_idx <= ia_idx;
        rd_off <= IA[2];
      end
      if ((state == S_FILL0) && MIACK)
        cap0 <= MID;
      if ((state == S_FILL1) && MIACK)
        cap1 <= MID;
    end
  end

  // RAM writes: sweep invalidates, fill writes data; the line becomes valid only with its last word
  always_ff @(posedge CLK) begin
    if (!RES && CE) begin
      if (state == S_CLEAR)
        valid_mem[clr_idx] <= 1'b0;
      if ((state == S_FILL0) && MIACK)
        data_mem[{rd_idx, 1'b0}] <= MID;
      if ((state == S_FILL1) && MIACK) begin
        data_mem[{rd_idx, 1'b1}] <= MID;
        tag_mem[rd_idx]          <= ia_tag;
        valid_mem[rd_idx]        <= 1'b1;
      end
    end
  end

endmodule
